// File: rtl/mem_pkg.sv
// Shared memory-block definitions: read collision modes and parameter legality.
package mem_pkg;

    localparam bit BYPASS_WRITE_FIRST = 1'b1;
    localparam bit BYPASS_READ_FIRST  = 1'b0;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // Nested tests keep the modulo away from a zero divisor when DATAW < 8.
    function automatic bit mem_params_legal(input int unsigned size,
                                            input int unsigned dataw,
                                            input int unsigned rd_lat);
        bit ok;
        ok = 1'b0;
        if ((rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX) && (dataw >= 8)) begin
            if ((dataw % 8) == 0) begin
                ok = ((size % (dataw / 8)) == 0);
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dpram_if.sv
// Write port, read-request and read-response signals of the dual-port RAM.
interface dpram_if #(
    parameter int unsigned ADDRW = 10,
    parameter int unsigned DATAW = 32
);
    localparam int unsigned MASKW = DATAW / 8;

    logic             wr_valid_i;
    logic [ADDRW-1:0] wr_addr_i;
    logic [DATAW-1:0] wr_data_i;
    logic [MASKW-1:0] wr_mask_i;
    logic             rd_valid_i;
    logic             rd_ready_o;
    logic [ADDRW-1:0] rd_addr_i;
    logic             rd_valid_o;
    logic [DATAW-1:0] rd_data_o;
    logic             rd_ready_i;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i,
        output rd_valid_i, rd_addr_i, rd_ready_i,
        input  rd_ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i,
        input  rd_valid_i, rd_addr_i, rd_ready_i,
        output rd_ready_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is presented whenever non-empty, zero otherwise.
module sync_fifo #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DATAW-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [DATAW-1:0] data_o
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wptr;
    logic [PTRW-1:0]  r_rptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : PTRW'(p + 1'b1);
    endfunction

    assign w_push  = push_i && (r_count != CNTW'(DEPTH));
    assign w_pop   = pop_i && (r_count != '0);
    assign valid_o = (r_count != '0);
    assign data_o  = valid_o ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= CNTW'(r_count + 1'b1);
            else if (!w_push && w_pop) r_count <= CNTW'(r_count - 1'b1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/dpram.sv
// Byte-masked dual-port RAM: never-stalling write port, pipelined read port with
// credit-based flow control into a show-ahead response FIFO.
module dpram
    import mem_pkg::*;
#(
    parameter int unsigned SIZE      = 1024,
    parameter int unsigned DATAW     = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter bit          BYPASS    = 1'b1,
    parameter              INIT_FILE = "",
    parameter int unsigned DEPTH     = SIZE / (DATAW / 8),
    parameter int unsigned ADDRW     = $clog2(SIZE),
    parameter int unsigned MASKW     = DATAW / 8
) (
    input  logic    clk_i,
    input  logic    rst_i,
    dpram_if.slave  bus
);

    localparam int unsigned FDEPTH = RD_LAT + 2;
    localparam int unsigned OFFW   = $clog2(MASKW);
    localparam int unsigned IDXW   = ADDRW - OFFW;
    localparam int unsigned CRW    = $clog2(FDEPTH + 1);

    if (!mem_params_legal(SIZE, DATAW, RD_LAT)) begin : g_bad_params
        $error("dpram: illegal parameters SIZE=%0d DATAW=%0d RD_LAT=%0d", SIZE, DATAW, RD_LAT);
    end

    if (INIT_FILE != "") begin : g_init_note
        $info("dpram: INIT_FILE is not loaded by the RTL; preload r_mem from simulation");
    end

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [IDXW-1:0]  w_wr_idx;
    logic [IDXW-1:0]  w_rd_idx;
    logic [DATAW-1:0] w_rd_word;
    logic [DATAW-1:0] w_merged;
    logic             w_collide;
    logic             w_accept;
    logic             w_pop;
    logic [RD_LAT-1:0] r_pv;
    logic [DATAW-1:0] r_pd [RD_LAT];
    logic [CRW-1:0]   r_credit;
    logic [CRW-1:0]   w_credit_nxt;
    logic             r_rd_ready;
    logic             w_fifo_valid;
    logic [DATAW-1:0] w_fifo_data;

    assign w_wr_idx = bus.wr_addr_i[ADDRW-1:OFFW];
    assign w_rd_idx = bus.rd_addr_i[ADDRW-1:OFFW];

    if (OFFW > 0) begin : g_lsbs
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^{bus.wr_addr_i[OFFW-1:0], bus.rd_addr_i[OFFW-1:0]};
    end

    // Write-first merges the colliding write's enabled lanes into the sampled word.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        w_collide = bus.wr_valid_i && (w_wr_idx == w_rd_idx);
        w_merged  = w_rd_word;
        if ((BYPASS == BYPASS_WRITE_FIRST) && w_collide) begin
            for (int i = 0; i < MASKW; i++) begin
                if (bus.wr_mask_i[i]) w_merged[8*i +: 8] = bus.wr_data_i[8*i +: 8];
            end
        end
    end

    // Array has no reset and keeps accepting writes while rst_i is high.
    always_ff @(posedge clk_i) begin
        if (bus.wr_valid_i) begin
            for (int i = 0; i < MASKW; i++) begin
                if (bus.wr_mask_i[i]) r_mem[w_wr_idx][8*i +: 8] <= bus.wr_data_i[8*i +: 8];
            end
        end
    end

    assign w_accept = bus.rd_valid_i && r_rd_ready;
    assign w_pop    = w_fifo_valid && bus.rd_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++) r_pv[i] <= r_pv[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) r_pd[0] <= w_merged;
        for (int i = 1; i < RD_LAT; i++) r_pd[i] <= r_pd[i-1];
    end

    always_comb begin
        w_credit_nxt = r_credit;
        if (w_accept && !w_pop)      w_credit_nxt = CRW'(r_credit + 1'b1);
        else if (!w_accept && w_pop) w_credit_nxt = CRW'(r_credit - 1'b1);
    end

    // Ready is precomputed from the next credit so rd_ready_o is a plain flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credit   <= '0;
            r_rd_ready <= 1'b1;
        end else begin
            r_credit   <= w_credit_nxt;
            r_rd_ready <= (w_credit_nxt < CRW'(FDEPTH));
        end
    end

    sync_fifo #(
        .DATAW (DATAW),
        .DEPTH (FDEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_pv[RD_LAT-1]),
        .data_i  (r_pd[RD_LAT-1]),
        .pop_i   (w_pop),
        .valid_o (w_fifo_valid),
        .data_o  (w_fifo_data)
    );

    assign bus.rd_ready_o = r_rd_ready;
    assign bus.rd_valid_o = w_fifo_valid;
    assign bus.rd_data_o  = w_fifo_data;

endmodule

// File: tb/tb_dpram.sv
// Bench for dpram: write-first and read-first instances driven in lockstep,
// responses checked against a queue filled from a byte-lane memory model.
module tb_dpram;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned FD     = RD_LAT + 2;
    localparam int          NV     = 17;

    typedef struct {
        logic        wr;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rd;
        logic [9:0]  raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] ea;
        logic [31:0] eb;
        int          ready_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        s_wr_valid = 1'b0;
    logic [9:0]  s_wr_addr  = '0;
    logic [31:0] s_wr_data  = '0;
    logic [3:0]  s_wr_mask  = '0;
    logic        s_rd_valid = 1'b0;
    logic [9:0]  s_rd_addr  = '0;
    logic        s_rd_ready = 1'b1;
    logic        s_use_exp  = 1'b0;
    logic [31:0] s_exp_a    = '0;
    logic [31:0] s_exp_b    = '0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t        q[$];
    logic [31:0] mdl [256];
    vec_t        vt [NV];

    dpram_if #(.ADDRW(10), .DATAW(32)) ifa ();
    dpram_if #(.ADDRW(10), .DATAW(32)) ifb ();

    assign ifa.wr_valid_i = s_wr_valid;  assign ifb.wr_valid_i = s_wr_valid;
    assign ifa.wr_addr_i  = s_wr_addr;   assign ifb.wr_addr_i  = s_wr_addr;
    assign ifa.wr_data_i  = s_wr_data;   assign ifb.wr_data_i  = s_wr_data;
    assign ifa.wr_mask_i  = s_wr_mask;   assign ifb.wr_mask_i  = s_wr_mask;
    assign ifa.rd_valid_i = s_rd_valid;  assign ifb.rd_valid_i = s_rd_valid;
    assign ifa.rd_addr_i  = s_rd_addr;   assign ifb.rd_addr_i  = s_rd_addr;
    assign ifa.rd_ready_i = s_rd_ready;  assign ifb.rd_ready_i = s_rd_ready;

    dpram #(.SIZE(1024), .DATAW(32), .RD_LAT(RD_LAT), .BYPASS(1'b1)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (ifa));
    dpram #(.SIZE(1024), .DATAW(32), .RD_LAT(RD_LAT), .BYPASS(1'b0)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [9:0] wa, input logic [31:0] wd,
                                input logic [3:0] wm, input logic rd, input logic [9:0] ra,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.wr = wr; v.waddr = wa; v.wdata = wd; v.wmask = wm;
        v.rd = rd; v.raddr = ra; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    // Negedge monitor: check outputs of the last edge, then model the coming edge.
    always @(negedge clk) begin
        exp_t        e;
        logic        ev;
        logic        rdy_m;
        logic [7:0]  ridx;
        logic [31:0] old;
        logic [31:0] mrg;
        if (rst) begin
            q.delete();
            chk("rst_valid_a", 32'(ifa.rd_valid_o), 32'd0);
            chk("rst_valid_b", 32'(ifb.rd_valid_o), 32'd0);
            chk("rst_ready_a", 32'(ifa.rd_ready_o), 32'd1);
            chk("rst_data_a",  ifa.rd_data_o,       32'd0);
        end else begin
            rdy_m = (q.size() < FD);
            chk("ready_a", 32'(ifa.rd_ready_o), 32'(rdy_m));
            chk("ready_b", 32'(ifb.rd_ready_o), 32'(rdy_m));
            ev = (q.size() > 0) && (q[0].ready_at <= cyc);
            chk("valid_a", 32'(ifa.rd_valid_o), 32'(ev));
            chk("valid_b", 32'(ifb.rd_valid_o), 32'(ev));
            if (ev) begin
                chk("data_a", ifa.rd_data_o, q[0].ea);
                chk("data_b", ifb.rd_data_o, q[0].eb);
                if (s_rd_ready) void'(q.pop_front());
            end
            if (s_rd_valid && rdy_m) begin
                ridx = s_rd_addr[9:2];
                old  = mdl[ridx];
                mrg  = old;
                if (s_wr_valid && (s_wr_addr[9:2] == ridx)) begin
                    for (int i = 0; i < 4; i++)
                        if (s_wr_mask[i]) mrg[8*i +: 8] = s_wr_data[8*i +: 8];
                end
                e.ea       = s_use_exp ? s_exp_a : mrg;
                e.eb       = s_use_exp ? s_exp_b : old;
                e.ready_at = cyc + 1 + int'(RD_LAT);
                q.push_back(e);
            end
        end
        if (s_wr_valid) begin
            for (int i = 0; i < 4; i++)
                if (s_wr_mask[i]) mdl[s_wr_addr[9:2]][8*i +: 8] = s_wr_data[8*i +: 8];
        end
    end

    task automatic idle();
        s_wr_valid = 1'b0; s_wr_mask = '0; s_rd_valid = 1'b0; s_use_exp = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && q.size() > 0; k++) step();
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int n_acc;
        vt[0]  = mk(1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 10'h000, 32'h0, 32'h0);
        vt[1]  = mk(1, 10'h010, 32'h000000AA, 4'h1, 0, 10'h000, 32'h0, 32'h0);
        vt[2]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h010, 32'hDEADBEAA, 32'hDEADBEAA);
        vt[3]  = mk(1, 10'h020, 32'h11223344, 4'hF, 0, 10'h000, 32'h0, 32'h0);
        vt[4]  = mk(1, 10'h020, 32'hFFFFFFFF, 4'h3, 1, 10'h020, 32'h1122FFFF, 32'h11223344);
        vt[5]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h022, 32'h1122FFFF, 32'h1122FFFF);
        vt[6]  = mk(1, 10'h013, 32'h55000000, 4'h8, 0, 10'h000, 32'h0, 32'h0);
        vt[7]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h011, 32'h55ADBEAA, 32'h55ADBEAA);
        vt[8]  = mk(1, 10'h3FC, 32'hCAFEF00D, 4'hF, 0, 10'h000, 32'h0, 32'h0);
        vt[9]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FF, 32'hCAFEF00D, 32'hCAFEF00D);
        vt[10] = mk(1, 10'h024, 32'hA5A5A5A5, 4'hF, 0, 10'h000, 32'h0, 32'h0);
        vt[11] = mk(1, 10'h025, 32'h01020304, 4'h6, 1, 10'h024, 32'hA50203A5, 32'hA5A5A5A5);
        vt[12] = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h024, 32'hA50203A5, 32'hA50203A5);
        vt[13] = mk(1, 10'h010, 32'h12345678, 4'h0, 1, 10'h010, 32'h55ADBEAA, 32'h55ADBEAA);
        vt[14] = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h020, 32'h1122FFFF, 32'h1122FFFF);
        vt[15] = mk(1, 10'h020, 32'h00000000, 4'hF, 0, 10'h000, 32'h0, 32'h0);
        vt[16] = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h020, 32'h00000000, 32'h00000000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors: masked writes, collisions, address LSBs, in-flight writes.
        for (int i = 0; i < NV; i++) begin
            s_wr_valid = vt[i].wr;  s_wr_addr = vt[i].waddr;
            s_wr_data  = vt[i].wdata; s_wr_mask = vt[i].wmask;
            s_rd_valid = vt[i].rd;  s_rd_addr = vt[i].raddr;
            s_use_exp  = vt[i].rd;  s_exp_a = vt[i].exp_a; s_exp_b = vt[i].exp_b;
            step();
        end
        idle();
        drain(40);

        // Fill a region, then stream 16 back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            s_wr_valid = 1'b1; s_wr_addr = 10'(10'h100 + 4 * i);
            s_wr_data = $urandom; s_wr_mask = 4'hF;
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            s_rd_valid = 1'b1; s_rd_addr = 10'(10'h100 + 4 * i);
            step();
        end
        idle();
        drain(40);

        // Consumer stalled: only FD reads may be accepted.
        s_rd_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            s_rd_valid = 1'b1; s_rd_addr = 10'(10'h100 + 4 * i);
            @(negedge clk);
            if (ifa.rd_ready_o) n_acc++;
            step();
        end
        chk("stall_accepts", 32'(n_acc), 32'(FD));
        chk("stall_ready", 32'(ifa.rd_ready_o), 32'd0);
        idle();
        repeat (3) step();
        s_rd_ready = 1'b1;
        drain(40);

        // Reset with three reads in flight; a write during reset must land.
        for (int i = 0; i < 3; i++) begin
            s_rd_valid = 1'b1; s_rd_addr = 10'(10'h100 + 4 * i);
            step();
        end
        idle();
        rst = 1'b1;
        s_wr_valid = 1'b1; s_wr_addr = 10'h040; s_wr_data = 32'h0BADF00D; s_wr_mask = 4'hF;
        @(negedge clk);
        chk("rst_credit", 32'(dut_a.r_credit), 32'd0);
        step();
        idle();
        rst = 1'b0;
        repeat (4) step();
        s_rd_valid = 1'b1; s_rd_addr = 10'h040;
        s_use_exp = 1'b1; s_exp_a = 32'h0BADF00D; s_exp_b = 32'h0BADF00D;
        step();
        s_use_exp = 1'b0; s_rd_addr = 10'h104;
        step();
        idle();
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
